// File: rtl/universal_shift_reg_pkg.sv
// Shared mode and state codes for the universal shift register.
// Imported by the top and the next-value function.
package universal_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/universal_shift_reg_next_value.sv
// Combinational next-q function: one operation applied to q.
// Shared by single-cycle ops and burst ops.
module usr_next_value
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] nq
);

    always_comb begin
        nq = q;
        unique case (mode)
            MODE_HOLD: nq = q;
            MODE_LOAD: nq = d;
            MODE_SHL:  nq = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  nq = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  nq = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  nq = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  nq = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  nq = '0;
            default:   nq = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with serial ends and
// a burst engine repeating one latched op count times.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    remaining;
    logic [2:0]       bmode;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] nq;
    logic             in_run;
    logic             take;
    logic             apply;

    assign in_run  = (state_q == ST_RUN);
    assign take    = (state_q == ST_IDLE) && start;
    assign op_mode = in_run ? bmode : mode;
    // A start accepted in IDLE suppresses that cycle's en op.
    assign apply   = in_run || (en && !take);

    usr_next_value #(
        .WIDTH(WIDTH)
    ) u_next (
        .mode (op_mode),
        .q    (q),
        .d    (d),
        .sin_l(sin_l),
        .sin_r(sin_r),
        .nq   (nq)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (count != '0))
                    state_d = ST_RUN;
                else if (start)
                    state_d = ST_DONE;
            end
            ST_RUN: begin
                if (remaining == CW'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q         <= '0;
            remaining <= '0;
            bmode     <= MODE_HOLD;
        end else begin
            if (apply)
                q <= nq;
            if (take) begin
                remaining <= count;
                bmode     <= mode;
            end else if (in_run) begin
                remaining <= remaining - CW'(1);
            end
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg against an
// arithmetic reference model of the op and burst rules.
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          en    = 1'b0;
    logic [2:0]    mode  = 3'd0;
    logic [W-1:0]  d     = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_q    = '0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    int           m_bm   = 0;

    universal_shift_reg #(
        .WIDTH(W),
        .CW   (CW)
    ) dut (
        .clock (clock),
        .clear (clear),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .count (count),
        .q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_op(input int md,
                                            input logic [W-1:0] cur);
        int v;
        int top;
        v   = int'(cur);
        top = 1 << (W - 1);
        case (md)
            0: return cur;
            1: return d;
            2: return W'((v * 2) % (2 * top) + int'(sin_r));
            3: return W'(v / 2 + int'(sin_l) * top);
            4: return W'((v * 2) % (2 * top) + v / top);
            5: return W'(v / 2 + (v % 2) * top);
            6: return W'(v / 2 + (v / top) * top);
            default: return '0;
        endcase
    endfunction

    // Advance model and DUT by one edge; outputs settle #1 later.
    task automatic tick();
        logic [W-1:0] nq;
        int nl;
        bit nd;
        int nb;
        nq = m_q;
        nl = m_left;
        nd = 1'b0;
        nb = m_bm;
        if (clear) begin
            nq = '0;
            nl = 0;
        end else if (m_left > 0) begin
            nq = ref_op(m_bm, m_q);
            nl = m_left - 1;
            nd = (nl == 0);
        end else if (!m_done && start) begin
            if (count > 0) begin
                nl = int'(count);
                nb = int'(mode);
            end else begin
                nd = 1'b1;
            end
        end else if (en) begin
            nq = ref_op(int'(mode), m_q);
        end
        @(posedge clock);
        #1;
        m_q    = nq;
        m_left = nl;
        m_done = nd;
        m_bm   = nb;
    endtask

    task automatic load(input logic [W-1:0] v);
        en = 1'b1;
        mode = 3'd1;
        d = v;
        start = 1'b0;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset: q=%h busy=%b done=%b want 00/0/0",
                     q, busy, done);
        end
        load(8'hA5);
        total++;
        if (q !== 8'hA5 || q !== m_q) begin
            bad++;
            $display("FAIL load: q=%h want a5", q);
        end
        total++;
        if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
            bad++;
            $display("FAIL sout: l=%b r=%b want 1/1", sout_l, sout_r);
        end
    endtask

    task automatic test_single_modes();
        logic [2:0] md [7]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        logic [W-1:0] ex [7] = '{8'h2D, 8'h4B, 8'h2D, 8'h4B,
                                 8'hCB, 8'h00, 8'h96};
        for (int i = 0; i < 7; i++) begin
            load(8'h96);
            en = 1'b1;
            mode = md[i];
            d = 8'h96;
            sin_r = 1'b1;
            sin_l = 1'b0;
            tick();
            en = 1'b0;
            total++;
            if (q !== ex[i] || q !== m_q) begin
                bad++;
                $display("FAIL mode%0d: q=%h want %h", md[i], q, ex[i]);
            end
        end
        load(8'h96);
        for (int i = 0; i < 8; i++) begin
            en = 1'b0;
            mode = 3'(i);
            d = 8'h11;
            tick();
            total++;
            if (q !== 8'h96) begin
                bad++;
                $display("FAIL en0 mode%0d: q=%h want 96", i, q);
            end
        end
    endtask

    task automatic test_burst();
        logic [W-1:0] seq [3] = '{8'h03, 8'h06, 8'h0C};
        int busy_cyc;
        load(8'h81);
        start = 1'b1;
        mode = 3'd4;
        count = 4'd3;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || q !== 8'h81) begin
            bad++;
            $display("FAIL burst_go: busy=%b q=%h want 1/81", busy, q);
        end
        busy_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy === 1'b1) busy_cyc++;
            mode = 3'($urandom_range(0, 7));
            en = 1'b1;
            d = 8'($urandom);
            tick();
            total++;
            if (q !== seq[i] || q !== m_q) begin
                bad++;
                $display("FAIL burst_q%0d: q=%h want %h", i, q, seq[i]);
            end
        end
        en = 1'b0;
        total++;
        if (busy_cyc != 3 || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL burst_end: busycyc=%0d busy=%b done=%b want 3/0/1",
                     busy_cyc, busy, done);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL burst_pulse: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_zero_burst();
        load(8'h3C);
        start = 1'b1;
        count = 4'd0;
        mode = 3'd7;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h3C) begin
            bad++;
            $display("FAIL zero: busy=%b done=%b q=%h want 0/1/3c",
                     busy, done, q);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_end: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        load(8'hFF);
        sin_l = 1'b0;
        start = 1'b1;
        mode = 3'd3;
        count = 4'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (q !== 8'h0F || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_mid: q=%h busy=%b want 0f/1", q, busy);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: q=%h busy=%b done=%b want 00/0/0",
                     q, busy, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL abort_done: done pulsed=1 want 0");
        end
        start = 1'b1;
        count = 4'd2;
        mode = 3'd1;
        d = 8'h77;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL restart: busy=%b want 1", busy);
        end
        tick();
        tick();
        total++;
        if (q !== 8'h77 || done !== 1'b1) begin
            bad++;
            $display("FAIL restart_end: q=%h done=%b want 77/1", q, done);
        end
        tick();
    endtask

    task automatic test_ignored();
        int ops;
        load(8'h01);
        start = 1'b1;
        mode = 3'd4;
        count = 4'd2;
        tick();
        ops = 0;
        for (int i = 0; i < 8 && busy === 1'b1; i++) begin
            count = 4'd7;
            tick();
            ops++;
        end
        total++;
        if (ops != 2 || q !== 8'h04 || done !== 1'b1) begin
            bad++;
            $display("FAIL ign_run: ops=%0d q=%h done=%b want 2/04/1",
                     ops, q, done);
        end
        start = 1'b1;
        en = 1'b1;
        mode = 3'd1;
        d = 8'h5A;
        tick();
        start = 1'b0;
        en = 1'b0;
        total++;
        if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ign_done: q=%h busy=%b done=%b want 5a/0/0",
                     q, busy, done);
        end
        tick();
        total++;
        if (busy !== 1'b0 || q !== 8'h5A) begin
            bad++;
            $display("FAIL ign_after: busy=%b q=%h want 0/5a", busy, q);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 49) == 0);
            en    = 1'($urandom);
            mode  = 3'($urandom);
            d     = 8'($urandom);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            start = ($urandom_range(0, 5) == 0);
            count = 4'($urandom);
            tick();
            total++;
            if (q !== m_q || busy !== (m_left > 0) || done !== m_done ||
                sout_l !== m_q[W-1] || sout_r !== m_q[0]) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand%0d: q=%h b=%b d=%b want %h/%b/%b",
                             i, q, busy, done, m_q, m_left > 0, m_done);
            end
        end
        clear = 1'b0;
        start = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_modes();
        test_burst();
        test_zero_burst();
        test_abort();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
